// File: rtl/hourly_chime_pkg.sv
// Shared types and helpers for the hourly chime.
// BCD limits, FSM state enum, hour decode functions.
package hourly_chime_pkg;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    GAP
  } state_e;

  // Both nibbles decimal and value within the limit.
  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    return (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) &&
           (v <= lim);
  endfunction

  // 24h BCD hour -> strike count 1..12.
  function automatic logic [3:0] hour_to_n(
    input logic [7:0] h
  );
    logic [4:0] b;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (b >= 5'd12) b = b - 5'd12;
    return (b == 5'd0) ? 4'd12 : b[3:0];
  endfunction

endpackage

// File: rtl/hourly_chime_tone_gen.sv
// Square-wave tone source for one burst.
// Ports: clk, rst_n, run (burst active), tone (out).
module chime_tone_gen
  import hourly_chime_pkg::*;
#(
  parameter int HALF_CYC = 25_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tone
);

  localparam int HW =
    (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam logic [HW-1:0] H_LAST =
    HW'(HALF_CYC - 1);

  logic [HW-1:0] hcnt_q;
  logic          ph_q;

  // Idle holds phase high so every burst
  // opens with a full high half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      ph_q   <= 1'b1;
    end else if (!run) begin
      hcnt_q <= '0;
      ph_q   <= 1'b1;
    end else if (hcnt_q == H_LAST) begin
      hcnt_q <= '0;
      ph_q   <= ~ph_q;
    end else begin
      hcnt_q <= hcnt_q + HW'(1);
    end
  end

  assign tone = run & ph_q;

endmodule

// File: rtl/hourly_chime.sv
// Strikes the hour on the buzzer at each xx:00:00.
// Ports: clk, rst_n, en, hour/min/sec (BCD), buzzer, busy, beeps_left.
module hourly_chime
  import hourly_chime_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TONE_HZ = 2_000,
  parameter int BEEP_MS = 200,
  parameter int GAP_MS  = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  output logic       buzzer,
  output logic       busy,
  output logic [3:0] beeps_left
);

  localparam int BEEP_CYC = CLK_HZ / 1000 * BEEP_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  localparam int HALF_CYC = CLK_HZ / (2 * TONE_HZ);
  localparam int MAX_CYC  =
    (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int CNT_W    =
    (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] BEEP_LAST =
    CNT_W'(BEEP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYC - 1);

  logic             match_d;
  logic             match_q;
  logic             match_q_d;
  logic             trig;
  logic             hour_ok_d;
  logic [3:0]       n_d;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       beeps_q;
  logic             busy_q;
  logic             tone;

  assign match_d   = ({min, sec} == 16'h0000);
  assign trig      = match_q & ~match_q_d;
  assign hour_ok_d = bcd_ok(hour, HOUR_MAX);
  assign n_d       = hour_to_n(hour);

  // Edge detect: a held 00:00 fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q   <= 1'b0;
      match_q_d <= 1'b0;
    end else begin
      match_q   <= match_d;
      match_q_d <= match_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beeps_q <= '0;
      busy_q  <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beeps_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (trig && hour_ok_d) begin
            state_q <= BEEP;
            beeps_q <= n_d;
            busy_q  <= 1'b1;
          end
        end
        BEEP: begin
          if (cnt_q == BEEP_LAST) begin
            cnt_q <= '0;
            if (beeps_q == 4'd1) begin
              state_q <= IDLE;
              beeps_q <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
              beeps_q <= beeps_q - 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= BEEP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          beeps_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  chime_tone_gen #(
    .HALF_CYC (HALF_CYC)
  ) u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == BEEP),
    .tone  (tone)
  );

  assign buzzer     = tone;
  assign busy       = busy_q;
  assign beeps_left = beeps_q;

endmodule

// File: tb/tb_hourly_chime.sv
// Bench for hourly_chime: timeline model plus
// directed literal checks and randomized rollovers.
module tb_hourly_chime;

  localparam int BEEP = 20;
  localparam int PER  = 50;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] hour = 8'h00;
  logic [7:0] min = 8'h59;
  logic [7:0] sec = 8'h59;
  logic       buzzer;
  logic       busy;
  logic [3:0] beeps_left;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hourly_chime #(
    .CLK_HZ  (1000),
    .TONE_HZ (100),
    .BEEP_MS (20),
    .GAP_MS  (30)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .buzzer     (buzzer),
    .busy       (busy),
    .beeps_left (beeps_left)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // A chime is a timeline: start edge, count N.
  // Offset o: burst k = o/50, w = o%50 inside period.
  int cyc = 0;
  bit s1 = 0, s2 = 0;
  bit act = 0;
  int start = 0, nb = 0, total = 0;

  function automatic bit m_valid(input logic [7:0] h);
    int hi, lo;
    hi = int'(h[7:4]);
    lo = int'(h[3:0]);
    return hi <= 9 && lo <= 9 && hi * 10 + lo <= 23;
  endfunction

  function automatic int m_n(input logic [7:0] h);
    int v;
    v = (int'(h[7:4]) * 10 + int'(h[3:0])) % 12;
    return (v == 0) ? 12 : v;
  endfunction

  initial forever begin
    bit was, trig;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      s1 = 0; s2 = 0; act = 0;
    end else begin
      was  = act;
      trig = s1 && !s2;
      s2   = s1;
      s1   = ({min, sec} == 16'h0000);
      if (!en) act = 0;
      else begin
        if (act && cyc - start >= total) act = 0;
        if (!was && trig && m_valid(hour)) begin
          act   = 1;
          start = cyc;
          nb    = m_n(hour);
          total = nb * PER - (PER - BEEP);
        end
      end
    end
  end

  initial forever begin
    int o, k, w;
    bit eb, ez;
    int el;
    @(negedge clk);
    eb = 0; ez = 0; el = 0;
    if (rst_n && act) begin
      o  = cyc - start;
      k  = o / PER;
      w  = o % PER;
      eb = 1;
      ez = (w < BEEP) && ((w / HALF) % 2 == 0);
      el = nb - k - ((w >= BEEP) ? 1 : 0);
    end
    chk("busy", 32'(busy), 32'(eb));
    chk("buzzer", 32'(buzzer), 32'(ez));
    chk("beeps_left", 32'(beeps_left), el);
  end

  // ---------------- directed ----------------
  task automatic idle_pre();
    min = 8'h59; sec = 8'h59;
    repeat (3) @(negedge clk);
  endtask

  task automatic rollover(input logic [7:0] hv,
                          input int hold,
                          input int win,
                          input int exp_busy,
                          input int exp_buz,
                          input int exp_max);
    int nbusy, nbuz, mx;
    idle_pre();
    nbusy = 0; nbuz = 0; mx = 0;
    hour = hv; min = 8'h00; sec = 8'h00;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      if (exp_busy > 0 && i == 0)
        chk("latency_pre", 32'(busy), 0);
      if (exp_busy > 0 && i == 1)
        chk("latency_rise", 32'(busy), 1);
      nbusy += int'(busy);
      nbuz  += int'(buzzer);
      if (int'(beeps_left) > mx) mx = int'(beeps_left);
      if (i == hold - 1) begin
        min = 8'h59; sec = 8'h59;
      end
    end
    chk("busy_cycles", nbusy, exp_busy);
    chk("buzz_cycles", nbuz, exp_buz);
    chk("max_beeps", mx, exp_max);
  endtask

  initial begin
    int nbusy;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_buzzer", 32'(buzzer), 0);
    chk("rst_beeps", 32'(beeps_left), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    rollover(8'h14, 3, 100, 70, 20, 2);
    rollover(8'h00, 3, 600, 570, 120, 12);
    rollover(8'h12, 3, 600, 570, 120, 12);
    rollover(8'h13, 3, 60, 20, 10, 1);
    rollover(8'h01, 2000, 2100, 20, 10, 1);

    // second edge while busy is ignored
    idle_pre();
    nbusy = 0;
    hour = 8'h05; min = 8'h00; sec = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      nbusy += int'(busy);
      if (i == 3)   begin min = 8'h59; sec = 8'h59; end
      if (i == 100) begin
        hour = 8'h09; min = 8'h00; sec = 8'h00;
      end
      if (i == 103) begin min = 8'h59; sec = 8'h59; end
    end
    chk("no_restart_busy", nbusy, 220);

    // en dropped at chime cycle 35, then raised
    idle_pre();
    nbusy = 0;
    hour = 8'h03; min = 8'h00; sec = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 3) begin min = 8'h59; sec = 8'h59; end
      if (i == 36) en = 1'b0;
      if (i == 37) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_beeps", 32'(beeps_left), 0);
      end
      if (i == 50) en = 1'b1;
      if (i > 50) nbusy += int'(busy);
    end
    chk("no_resume", nbusy, 0);

    // async reset mid-burst
    idle_pre();
    hour = 8'h02; min = 8'h00; sec = 8'h00;
    repeat (4) @(negedge clk);
    min = 8'h59; sec = 8'h59;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_buzzer", 32'(buzzer), 0);
    chk("async_beeps", 32'(beeps_left), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      nbusy += int'(busy);
    end
    chk("post_rst_quiet", nbusy, 0);
    rollover(8'h02, 3, 100, 70, 20, 2);

    // invalid hours
    rollover(8'h1A, 3, 100, 0, 0, 0);
    rollover(8'h24, 3, 100, 0, 0, 0);

    // ---------------- randomized ----------------
    for (int it = 0; it < 30; it++) begin
      int hold, len, drop_at, drop_len, rst_at;
      logic [7:0] hv;
      if ($urandom_range(0, 4) == 0)
        hv = 8'($urandom);
      else begin
        int h;
        h  = int'($urandom_range(0, 23));
        hv = {4'(h / 10), 4'(h % 10)};
      end
      hold     = int'($urandom_range(1, 6));
      len      = int'($urandom_range(40, 700));
      drop_at  = ($urandom_range(0, 1) == 0) ?
                 int'($urandom_range(8, 400)) : -1;
      drop_len = int'($urandom_range(1, 5));
      rst_at   = ($urandom_range(0, 6) == 0) ?
                 int'($urandom_range(10, 300)) : -1;
      hour = hv; min = 8'h00; sec = 8'h00;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if (i == hold) begin
          min = 8'($urandom_range(1, 89));
          sec = 8'($urandom);
        end
        if (i == drop_at) en = 1'b0;
        if (i == drop_at + drop_len) en = 1'b1;
        if (i == rst_at) #2 rst_n = 1'b0;
        if (rst_at >= 0 && i == rst_at + 2)
          rst_n = 1'b1;
      end
      en = 1'b1; rst_n = 1'b1;
      min = 8'h59; sec = 8'h59;
      repeat (3) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
